// File: rtl/aileron_slew_ctrl.sv
// aileron_slew_ctrl: rate limiter for the aileron angle command.
// Accepts a signed 4-bit target through valid/ready and moves the registered
// output 'angulacao' one step toward it every TICK_DIV clocks. An invalid
// target (4'b1000) forces a sticky fault that ramps back to zero and waits for
// limpa_erro.
module aileron_slew_ctrl #(
    parameter int TICK_DIV = 1000,
    parameter int MAX_ANG  = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alvo_valid,
    input  logic [3:0] alvo,
    output logic       alvo_ready,
    input  logic       limpa_erro,
    output logic [3:0] angulacao,
    output logic       em_movimento,
    output logic       chegou,
    output logic       erro
);

    localparam int               DIV_W       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(TICK_DIV - 1);
    localparam logic signed [3:0] ANG_MAX    = 4'(MAX_ANG);
    localparam logic signed [3:0] ANG_MIN    = -ANG_MAX;
    localparam logic [3:0]       ANG_INVALID = 4'b1000;

    typedef enum logic [1:0] {IDLE, MOVE, FAULT} state_t;

    state_t                  state;
    logic signed [3:0]       ang;
    logic signed [3:0]       target;
    logic [DIV_W-1:0]        div;

    logic signed [3:0]       goal;
    logic signed [3:0]       step_ang;
    logic signed [3:0]       alvo_sat;
    logic [DIV_W-1:0]        div_next;
    logic                    counting;
    logic                    tick;
    logic                    xfer;
    logic                    alvo_bad;

    // Saturate an accepted target to the mechanical limits.
    function automatic logic signed [3:0] clamp_ang(input logic signed [3:0] a);
        logic signed [3:0] r;
        r = a;
        if (a > ANG_MAX) r = ANG_MAX;
        else if (a < ANG_MIN) r = ANG_MIN;
        return r;
    endfunction

    // Move one unit from a toward g (no change when already there).
    function automatic logic signed [3:0] step_toward(input logic signed [3:0] a,
                                                       input logic signed [3:0] g);
        logic signed [3:0] r;
        r = a;
        if (a < g) r = a + 4'sd1;
        else if (a > g) r = a - 4'sd1;
        return r;
    endfunction

    assign angulacao = ang;

    // Step decision for this edge: the goal in force before the edge is used.
    always_comb begin
        goal     = (state == FAULT) ? 4'sd0 : target;
        counting = (state == MOVE) || ((state == FAULT) && (ang != 4'sd0));
        tick     = (div == DIV_LAST);
        step_ang = (counting && tick) ? step_toward(ang, goal) : ang;
        xfer     = alvo_valid && alvo_ready;
        alvo_bad = (alvo == ANG_INVALID);
        alvo_sat = clamp_ang($signed(alvo));
        div_next = tick ? '0 : div + 1'b1;
    end

    // Control FSM with registered outputs; divider keeps its phase across retargets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ang          <= 4'sd0;
            target       <= 4'sd0;
            div          <= '0;
            alvo_ready   <= 1'b1;
            em_movimento <= 1'b0;
            chegou       <= 1'b0;
            erro         <= 1'b0;
        end else begin
            chegou <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        div <= '0;
                        if (alvo_bad) begin
                            state        <= FAULT;
                            erro         <= 1'b1;
                            alvo_ready   <= 1'b0;
                            em_movimento <= (ang != 4'sd0);
                        end else begin
                            target <= alvo_sat;
                            if (alvo_sat == ang) begin
                                chegou <= 1'b1;
                            end else begin
                                state        <= MOVE;
                                em_movimento <= 1'b1;
                            end
                        end
                    end
                end
                MOVE: begin
                    ang <= step_ang;
                    if (xfer && alvo_bad) begin
                        state        <= FAULT;
                        erro         <= 1'b1;
                        alvo_ready   <= 1'b0;
                        em_movimento <= (step_ang != 4'sd0);
                        div          <= (step_ang != 4'sd0) ? div_next : '0;
                    end else if ((xfer && (alvo_sat == step_ang)) ||
                                 (!xfer && (target == step_ang))) begin
                        if (xfer) target <= alvo_sat;
                        state        <= IDLE;
                        chegou       <= 1'b1;
                        em_movimento <= 1'b0;
                        div          <= '0;
                    end else begin
                        if (xfer) target <= alvo_sat;
                        div <= div_next;
                    end
                end
                FAULT: begin
                    ang <= step_ang;
                    if (limpa_erro && (ang == 4'sd0)) begin
                        state        <= IDLE;
                        erro         <= 1'b0;
                        target       <= 4'sd0;
                        alvo_ready   <= 1'b1;
                        em_movimento <= 1'b0;
                        div          <= '0;
                    end else begin
                        em_movimento <= (step_ang != 4'sd0);
                        div          <= (counting && (step_ang != 4'sd0)) ? div_next : '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aileron_slew_ctrl.sv
// Testbench for aileron_slew_ctrl: directed scenarios followed by random
// traffic, every cycle compared against a schedule-based reference model.
module tb_aileron_slew_ctrl;

    localparam int TICK = 4;
    localparam int MAXA = 5;

    logic       clk;
    logic       rst_n;
    logic       alvo_valid;
    logic [3:0] alvo;
    logic       alvo_ready;
    logic       limpa_erro;
    logic [3:0] angulacao;
    logic       em_movimento;
    logic       chegou;
    logic       erro;

    aileron_slew_ctrl #(.TICK_DIV(TICK), .MAX_ANG(MAXA)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alvo_valid   (alvo_valid),
        .alvo         (alvo),
        .alvo_ready   (alvo_ready),
        .limpa_erro   (limpa_erro),
        .angulacao    (angulacao),
        .em_movimento (em_movimento),
        .chegou       (chegou),
        .erro         (erro)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Reference model: angle, target, and the absolute cycle of the next step.
    int m_ang, m_tgt, m_next, cyc;
    bit m_fault, m_mov, m_cheg, m_erro;

    function automatic int mclamp(input int a);
        if (a > MAXA) return MAXA;
        if (a < -MAXA) return -MAXA;
        return a;
    endfunction

    task automatic model_reset();
        m_ang = 0; m_tgt = 0; m_next = 0;
        m_fault = 0; m_mov = 0; m_cheg = 0; m_erro = 0;
    endtask

    task automatic model_edge();
        int goal, nang;
        bit act, stp, xfer;
        cyc++;
        goal = m_fault ? 0 : m_tgt;
        act  = m_fault ? (m_ang != 0) : m_mov;
        stp  = act && (cyc == m_next);
        nang = m_ang;
        if (stp) begin
            if (goal > m_ang) nang = m_ang + 1;
            else if (goal < m_ang) nang = m_ang - 1;
            m_next = m_next + TICK;
        end
        xfer = alvo_valid && !m_fault;
        m_cheg = 0;
        if (m_fault) begin
            if (limpa_erro && m_ang == 0) begin
                m_fault = 0; m_erro = 0; m_tgt = 0;
            end
        end else if (xfer && alvo == 4'b1000) begin
            m_fault = 1; m_erro = 1; m_mov = 0;
            if (!act) m_next = cyc + TICK;
        end else if (xfer) begin
            m_tgt = mclamp(int'($signed(alvo)));
            if (nang == m_tgt) begin
                m_mov = 0; m_cheg = 1;
            end else if (!m_mov) begin
                m_mov = 1; m_next = cyc + TICK;
            end
        end else if (m_mov && stp && nang == m_tgt) begin
            m_mov = 0; m_cheg = 1;
        end
        m_ang = nang;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " angulacao"}, int'($signed(angulacao)), m_ang);
        chk({tag, " alvo_ready"}, int'(alvo_ready), int'(!m_fault));
        chk({tag, " em_movimento"}, int'(em_movimento), int'(m_mov || (m_fault && m_ang != 0)));
        chk({tag, " chegou"}, int'(chegou), int'(m_cheg));
        chk({tag, " erro"}, int'(erro), int'(m_erro));
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    task automatic offer(input string tag, input logic [3:0] a);
        alvo_valid = 1'b1;
        alvo       = a;
        cycle(tag);
        alvo_valid = 1'b0;
    endtask

    task automatic run_until_ang(input string tag, input int a);
        for (int i = 0; i < 200 && m_ang != a; i++) cycle(tag);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset(input string tag);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; alvo_valid = 1'b0; alvo = 4'd0; limpa_erro = 1'b0;
        cyc = 0;
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;

        // Ramp 0 -> +5, then back to 0
        offer("up5", 4'd5);
        run("up5", 24);
        offer("down0", 4'd0);
        run("down0", 24);

        // Ramp 0 -> -3, then back to 0
        offer("neg3", 4'b1101);
        run("neg3", 16);
        offer("ret0", 4'd0);
        run("ret0", 16);

        // Retarget to -1 while heading to +5
        offer("retgt", 4'd5);
        run_until_ang("retgt", 2);
        run("retgt", 1);
        offer("retgt", 4'b1111);
        run("retgt", 20);

        // Invalid target at +3, offers ignored, early clear ignored, clear at 0
        offer("to3", 4'd3);
        run("to3", 20);
        offer("fault", 4'b1000);
        alvo_valid = 1'b1; alvo = 4'd2;
        run("fault", 6);
        limpa_erro = 1'b1;
        run("early_clr", 2);
        limpa_erro = 1'b0; alvo_valid = 1'b0;
        run("fault", 12);
        limpa_erro = 1'b1;
        run("clr", 2);
        limpa_erro = 1'b0;
        run("clr", 2);

        // Clamp: +7 stops at +5; re-accepting +5 gives an immediate arrival
        offer("clamp", 4'd7);
        run("clamp", 24);
        offer("same", 4'd5);
        run("same", 3);

        // Asynchronous reset mid-ramp at +3, then a fresh one-step move
        offer("rst_mid", 4'd0);
        run_until_ang("rst_mid", 3);
        run("rst_mid", 1);
        async_reset("rst_mid");
        offer("post_rst", 4'd1);
        run("post_rst", 6);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            alvo_valid = ($urandom_range(0, 9) < 3);
            alvo       = 4'($urandom);
            limpa_erro = ($urandom_range(0, 9) < 2);
            if ($urandom_range(0, 599) == 0) async_reset("rand_rst");
            else cycle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
